// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RV32 pipeline stage registers.
package riscv_pipe_pkg;

   localparam int          RV32_XLEN = 32;
   localparam logic [31:0] RV32_NOP  = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } stage_state_t;

   typedef struct packed {
      logic [RV32_XLEN-1:0] instr;
      logic [RV32_XLEN-1:0] pc;
   } ifid_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry payload skid buffer: M drives the consumer, S catches the extra beat
// so the producer-side ready can be a flop.
//   state    | meaning
//   ST_EMPTY | nothing held, ready
//   ST_ONE   | M valid, ready
//   ST_TWO   | M and S valid, not ready
module pipe_skid_buf
   import riscv_pipe_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_clear,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_data
);

   stage_state_t      r_state;
   logic [DATA_W-1:0] r_main;
   logic [DATA_W-1:0] r_skid;
   logic              r_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_EMPTY;
         r_main  <= '0;
         r_skid  <= '0;
         r_ready <= 1'b1;
      end else if (i_clear) begin
         r_state <= ST_EMPTY;
         r_ready <= 1'b1;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (i_push) begin
                  r_main  <= i_data;
                  r_state <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (i_push && i_pop) begin
                  r_main <= i_data;
               end else if (i_push) begin
                  r_skid  <= i_data;
                  r_state <= ST_TWO;
                  r_ready <= 1'b0;
               end else if (i_pop) begin
                  r_state <= ST_EMPTY;
               end
            end
            ST_TWO: begin
               // ready is low here, so a push cannot arrive alongside the pop
               if (i_pop) begin
                  r_main  <= r_skid;
                  r_state <= ST_ONE;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_EMPTY;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign o_valid = (r_state != ST_EMPTY);
   assign o_ready = r_ready;
   assign o_data  = r_main;

endmodule

// File: rtl/ifid_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake, hazard stall, branch flush,
// optional skid buffer and a saturating decode-bubble counter.
module ifid_pipe_stage
   import riscv_pipe_pkg::*;
#(
   parameter int                 INSTR_W   = 32,
   parameter int                 PC_W      = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(RV32_NOP),
   parameter bit                 SKID      = 1'b1,
   parameter int                 CNT_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic               stall,
   input  logic               flush,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [CNT_W-1:0]   bubble_cnt
);

   localparam int PL_W = INSTR_W + PC_W;

   logic            w_in_fire;
   logic            w_out_fire;
   logic            w_valid;
   logic            w_ready;
   logic [PL_W-1:0] w_main;
   logic [CNT_W-1:0] r_bubble_cnt;

   assign w_in_fire  = in_valid & w_ready & ~stall & ~flush;
   assign w_out_fire = w_valid & out_ready & ~stall;

   generate
      if (SKID) begin : g_skid
         pipe_skid_buf #(
            .DATA_W (PL_W)
         ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_in_fire),
            .i_pop   (w_out_fire),
            .i_clear (flush),
            .i_data  ({in_instr, in_pc}),
            .o_valid (w_valid),
            .o_ready (w_ready),
            .o_data  (w_main)
         );
      end else begin : g_single
         logic            r_valid;
         logic [PL_W-1:0] r_main;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid <= 1'b0;
               r_main  <= '0;
            end else if (flush) begin
               r_valid <= 1'b0;
            end else if (w_in_fire) begin
               r_main  <= {in_instr, in_pc};
               r_valid <= 1'b1;
            end else if (w_out_fire) begin
               r_valid <= 1'b0;
            end
         end

         assign w_valid = r_valid;
         assign w_main  = r_main;
         // single entry can refill in the same cycle the consumer drains it
         assign w_ready = ~r_valid | (out_ready & ~stall);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bubble_cnt <= '0;
      end else if (~w_valid & out_ready & ~stall & ~(&r_bubble_cnt)) begin
         r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
   end

   assign in_ready   = w_ready;
   assign out_valid  = w_valid;
   assign out_instr  = w_valid ? w_main[PL_W-1:PC_W] : NOP_INSTR;
   assign out_pc     = w_valid ? w_main[PC_W-1:0] : '0;
   assign bubble_cnt = r_bubble_cnt;

endmodule
